// File: rtl/avn_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avn_mem_responder_pkg
// Brief    : Shared Avalon-MM request/response types and responder constants.
// Revision : 1.0 - initial release
// ============================================================================
package avn_mem_responder_pkg;

  localparam int          AVN_ADDR_W   = 32;
  localparam logic [31:0] AVN_ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [AVN_ADDR_W-1:0] address;
    logic [31:0]           writedata;
    logic [3:0]            byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } avn_state_e;

endpackage
`default_nettype wire

// File: rtl/avn_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : avn_mem_responder_if
// Brief    : Avalon-MM request/response bundle between cache and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface avn_mem_responder_if;
  import avn_mem_responder_pkg::*;

  avalon_req_t  mem_avn_req;
  avalon_resp_t mem_avn_resp;

  modport master (output mem_avn_req, input mem_avn_resp);
  modport slave  (input mem_avn_req, output mem_avn_resp);
endinterface
`default_nettype wire

// File: rtl/avn_mem_bram.sv
`default_nettype none
// ============================================================================
// Module   : avn_mem_bram
// Brief    : Single-port 32-bit RAM, byte-lane write enables, async read.
// Revision : 1.0 - initial release
// ============================================================================
module avn_mem_bram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic [IDX_W-1:0] i_addr,
  input  wire logic             i_we,
  input  wire logic [3:0]       i_be,
  input  wire logic [31:0]      i_wdata,
  output logic      [31:0]      o_rdata
);

  // Storage is deliberately never reset: contents survive rst_n.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/avn_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : avn_mem_responder
// Brief    : Avalon-MM memory responder with programmable wait states.
//            Optional macro AVN_MEM_BOUNDS_CHECK_EN enables range checking.
// Revision : 1.0 - initial release
// ============================================================================
module avn_mem_responder
  import avn_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  avn_mem_responder_if.slave  mem_avn,
  output logic                bound_err
);

  localparam int         c_IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

  logic                  w_rd, w_wr, w_req;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_upper_nz;
  logic [31:0]           w_mem_rdata, w_rd_value;
  logic                  w_we, w_load;
  logic                  w_unused;

  avn_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_readdata;

  assign w_rd   = mem_avn.mem_avn_req.read;
  assign w_wr   = mem_avn.mem_avn_req.write;
  assign w_req  = w_rd | w_wr;
  assign w_addr = mem_avn.mem_avn_req.address[ADDR_WIDTH-1:0];
  assign w_idx  = w_addr[c_IDX_W+1:2];

  generate
    if (ADDR_WIDTH > c_IDX_W + 2) begin : g_upper
      assign w_upper_nz = |w_addr[ADDR_WIDTH-1:c_IDX_W+2];
    end else begin : g_no_upper
      assign w_upper_nz = 1'b0;
    end
  endgenerate

  assign w_unused = ^{w_addr[1:0], w_upper_nz};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // BUSY leaves when the decremented count reaches zero, so waitrequest is
  // high for exactly WAIT_STATES+1 cycles (IDLE plus WAIT_STATES BUSY).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (c_WAIT == 4'd0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = c_WAIT;
          end
        end
      end
      ST_BUSY: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_load = (w_state_nxt == ST_DONE) && (r_state != ST_DONE) && w_rd;

`ifdef AVN_MEM_BOUNDS_CHECK_EN
  assign w_we       = (r_state == ST_DONE) && w_wr && !w_upper_nz;
  assign w_rd_value = w_upper_nz ? AVN_ERR_DATA : w_mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         bound_err <= 1'b0;
    else if ((r_state == ST_DONE) && w_req && w_upper_nz) bound_err <= 1'b1;
  end
`else
  assign w_we       = (r_state == ST_DONE) && w_wr;
  assign w_rd_value = w_mem_rdata;
  assign bound_err  = 1'b0;
`endif

  // Sampled on entry to DONE, before the same access's write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_readdata <= 32'd0;
    else if (w_load) r_readdata <= w_rd_value;
  end

  avn_mem_bram #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (c_IDX_W)
  ) u_bram (
    .clk     (clk),
    .i_addr  (w_idx),
    .i_we    (w_we),
    .i_be    (mem_avn.mem_avn_req.byte_enable),
    .i_wdata (mem_avn.mem_avn_req.writedata),
    .o_rdata (w_mem_rdata)
  );

  assign mem_avn.mem_avn_resp = '{readdata:    r_readdata,
                                  waitrequest: w_req && (r_state != ST_DONE)};

endmodule
`default_nettype wire

// File: tb/tb_avn_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avn_mem_responder
// Brief    : Directed self-checking bench for avn_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avn_mem_responder;
  import avn_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic bound_err0, bound_err1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  avn_mem_responder_if if0 ();
  avn_mem_responder_if if1 ();

  avn_mem_responder #(.ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .mem_avn (if0.slave), .bound_err (bound_err0));

  avn_mem_responder #(.ADDR_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .mem_avn (if1.slave), .bound_err (bound_err1));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    avalon_req_t req;
    req = '{read: rd, write: wr, address: addr, writedata: data, byte_enable: be};
    if (sel) if1.mem_avn_req = req;
    else     if0.mem_avn_req = req;
  endtask

  function automatic logic wait_of(input bit sel);
    return sel ? if1.mem_avn_resp.waitrequest : if0.mem_avn_resp.waitrequest;
  endfunction

  function automatic logic [31:0] rdata_of(input bit sel);
    return sel ? if1.mem_avn_resp.readdata : if0.mem_avn_resp.readdata;
  endfunction

  // Runs one access to completion; returns the number of waitrequest-high cycles.
  task automatic access(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output int waits);
    bit done = 1'b0;
    waits = 0;
    drive(sel, rd, wr, addr, data, be);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wait_of(sel)) waits++;
      else              done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) check_val("access_timeout", 32'd1, 32'd0);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    int          w;
    logic [7:0]  pat;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #12;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    #1;
    check_val("rst_wait_with_req", 32'(wait_of(1'b0)), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    check_val("rst_wait_idle", 32'(wait_of(1'b0)), 32'd0);
    check_val("rst_readdata", rdata_of(1'b0), 32'd0);
    check_val("rst_bound_err", 32'(bound_err0), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, w);
    check_val("wr_wait_cycles", 32'(w), 32'd3);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, w);
    check_val("rd_wait_cycles", 32'(w), 32'd3);
    check_val("rd_full_word", rdata_of(1'b0), 32'hCAFEF00D);

    // Partial byte-lane write
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h11112222, 4'b0011, w);
    check_val("rd_held_over_write", rdata_of(1'b0), 32'hCAFEF00D);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, w);
    check_val("rd_partial_be", rdata_of(1'b0), 32'hCAFE2222);

    // Simultaneous read+write: old word returned, new word stored
    access(1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, w);
    check_val("rdwr_old_word", rdata_of(1'b0), 32'hCAFE2222);
    access(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 4'h0, w);
    check_val("rdwr_new_word_lowbits", rdata_of(1'b0), 32'h12345678);

    // Reset in the middle of a write
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h55550000, 4'hF, w);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_readdata", rdata_of(1'b0), 32'd0);
    check_val("midrst_wait", 32'(wait_of(1'b0)), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, w);
    check_val("midrst_prior_value", rdata_of(1'b0), 32'h55550000);

    // Request withdrawn during BUSY: no write
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h01020304, 4'hF, w);
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, w);
    check_val("abort_no_write", rdata_of(1'b0), 32'h01020304);

    // Held request completes repeatedly: 1,1,1,0 per access
    pat = 8'd0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); pat = {pat[6:0], wait_of(1'b0)};
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    check_val("b2b_wait_pattern", 32'(pat), 32'hEE);

    // Out-of-range address
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, w);
    access(1'b0, 1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, w);
`ifdef AVN_MEM_BOUNDS_CHECK_EN
    check_val("oob_rd_errdata", rdata_of(1'b0), 32'hDEADBEEF);
    check_val("oob_bound_err", 32'(bound_err0), 32'd1);
    access(1'b0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, w);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0, w);
    check_val("oob_wr_dropped", rdata_of(1'b0), 32'h0BADF00D);
    check_val("oob_bound_err_sticky", 32'(bound_err0), 32'd1);
`else
    check_val("oob_rd_alias", rdata_of(1'b0), 32'h0BADF00D);
    check_val("oob_bound_err_zero", 32'(bound_err0), 32'd0);
`endif

    // Zero-wait-state instance
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A55A5A, 4'hF, w);
    check_val("ws0_wr_wait_cycles", 32'(w), 32'd1);
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 4'h0, w);
    check_val("ws0_rd_wait_cycles", 32'(w), 32'd1);
    check_val("ws0_rd_data", rdata_of(1'b1), 32'hA5A55A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
